// File: rtl/rect_plotter.sv
// Rectangle fill engine: accepts one rectangle request and streams its pixels in raster
// order to a frame-buffer write port, one pixel per cycle, clipping off-screen pixels.
module rect_plotter #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic       clock,
    input  logic       resetn,

    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [7:0] req_w,
    input  logic [6:0] req_h,
    input  logic [2:0] req_color,

    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [2:0] color,
    output logic       plot,
    output logic       done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRAW   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);

    logic [1:0] state_q, state_d;
    logic       ready_q;

    // Request fields captured at acceptance
    logic [7:0] x_q;
    logic [6:0] y_q;
    logic [7:0] w_q;
    logic [6:0] h_q;
    logic [2:0] color_q;

    // Raster offsets within the rectangle
    logic [7:0] col_q, col_d;
    logic [6:0] row_q, row_d;

    logic       accept;
    logic       req_empty;
    logic       col_last;
    logic       row_last;
    logic [8:0] x_sum;
    logic [7:0] y_sum;
    logic       on_screen;

    assign accept    = req_valid && ready_q;
    assign req_empty = (req_w == 8'd0) || (req_h == 7'd0);
    assign col_last  = (col_q == w_q - 8'd1);
    assign row_last  = (row_q == h_q - 7'd1);

    // Sums are one bit wider than the coordinates so that wrap-around reads as off-screen
    assign x_sum     = {1'b0, x_q} + {1'b0, col_q};
    assign y_sum     = {1'b0, y_q} + {1'b0, row_q};
    assign on_screen = (x_sum < X_LIMIT) && (y_sum < Y_LIMIT);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    col_d   = 8'd0;
                    row_d   = 7'd0;
                    state_d = req_empty ? FINISH : DRAW;
                end
            end
            DRAW: begin
                if (col_last) begin
                    col_d = 8'd0;
                    if (row_last) begin
                        row_d   = 7'd0;
                        state_d = FINISH;
                    end else begin
                        row_d = row_q + 7'd1;
                    end
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            col_q   <= 8'd0;
            row_q   <= 7'd0;
            x_q     <= 8'd0;
            y_q     <= 7'd0;
            w_q     <= 8'd0;
            h_q     <= 7'd0;
            color_q <= 3'd0;
        end else begin
            state_q <= state_d;
            // Registered so ready rises on the first edge after reset release
            ready_q <= (state_d == IDLE);
            col_q   <= col_d;
            row_q   <= row_d;
            if (accept) begin
                x_q     <= req_x;
                y_q     <= req_y;
                w_q     <= req_w;
                h_q     <= req_h;
                color_q <= req_color;
            end
        end
    end

    // Outputs decode directly from reset-cleared state so reset takes effect without a clock
    assign req_ready = ready_q;
    assign plot      = (state_q == DRAW) && on_screen;
    assign done      = (state_q == FINISH);
    assign plot_x    = x_sum[7:0];
    assign plot_y    = y_sum[6:0];
    assign color     = color_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Directed self-checking bench for rect_plotter: reset, basic fill, empty requests,
// clipping, full screen, back-to-back requests and mid-draw reset.
module tb_rect_plotter;

    logic       clock;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [7:0] req_w;
    logic [6:0] req_h;
    logic [2:0] req_color;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] color;
    logic       plot;
    logic       done;

    int n_checks;
    int n_fail;

    rect_plotter #(
        .SCREEN_W(160),
        .SCREEN_H(120)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_x    (req_x),
        .req_y    (req_y),
        .req_w    (req_w),
        .req_h    (req_h),
        .req_color(req_color),
        .plot_x   (plot_x),
        .plot_y   (plot_y),
        .color    (color),
        .plot     (plot),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input logic [7:0] x, input logic [6:0] y, input logic [7:0] w,
                             input logic [6:0] h, input logic [2:0] c);
        req_x     = x;
        req_y     = y;
        req_w     = w;
        req_h     = h;
        req_color = c;
        req_valid = 1'b1;
    endtask

    task automatic test_reset();
        step();
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        n_checks++; if (plot !== 1'b0) begin n_fail++; $display("FAIL rst_plot: got %b want 0", plot); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (plot_x !== 8'd0 || plot_y !== 7'd0) begin n_fail++; $display("FAIL rst_xy: got (%0d,%0d) want (0,0)", plot_x, plot_y); end
        n_checks++; if (color !== 3'd0) begin n_fail++; $display("FAIL rst_color: got %0d want 0", color); end
        resetn = 1'b1;
        step();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
        n_checks++; if (done !== 1'b0 || plot !== 1'b0) begin n_fail++; $display("FAIL rst_release_idle: got plot=%b done=%b want 0/0", plot, done); end
    endtask

    task automatic test_basic();
        logic [7:0] ex;
        logic [6:0] ey;
        drive_req(8'd10, 7'd5, 8'd3, 7'd2, 3'b100);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", req_ready); end
        step();
        // Inputs scrambled after acceptance must not leak into the rectangle
        req_valid = 1'b0;
        req_x = 8'd99; req_y = 7'd77; req_w = 8'd1; req_h = 7'd1; req_color = 3'b011;
        for (int k = 0; k < 6; k++) begin
            ex = 8'(10 + k % 3);
            ey = 7'(5 + k / 3);
            n_checks++; if (plot !== 1'b1) begin n_fail++; $display("FAIL basic_plot k=%0d: got %b want 1", k, plot); end
            n_checks++; if (plot_x !== ex || plot_y !== ey) begin n_fail++; $display("FAIL basic_xy k=%0d: got (%0d,%0d) want (%0d,%0d)", k, plot_x, plot_y, ex, ey); end
            n_checks++; if (color !== 3'b100) begin n_fail++; $display("FAIL basic_color k=%0d: got %b want 100", k, color); end
            n_checks++; if (done !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ctrl k=%0d: got done=%b ready=%b want 0/0", k, done, req_ready); end
            step();
        end
        n_checks++; if (done !== 1'b1 || plot !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done=%b plot=%b want 1/0", done, plot); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL basic_finish_ready: got %b want 0", req_ready); end
        step();
        n_checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle: got done=%b ready=%b want 0/1", done, req_ready); end
    endtask

    task automatic test_empty();
        // w = 0
        drive_req(8'd5, 7'd5, 8'd0, 7'd7, 3'b111);
        step();
        req_valid = 1'b0;
        n_checks++; if (done !== 1'b1 || plot !== 1'b0) begin n_fail++; $display("FAIL empty_w_done: got done=%b plot=%b want 1/0", done, plot); end
        step();
        n_checks++; if (done !== 1'b0 || req_ready !== 1'b1 || plot !== 1'b0) begin n_fail++; $display("FAIL empty_w_idle: got done=%b ready=%b plot=%b want 0/1/0", done, req_ready, plot); end
        // h = 0
        drive_req(8'd5, 7'd5, 8'd9, 7'd0, 3'b111);
        step();
        req_valid = 1'b0;
        n_checks++; if (done !== 1'b1 || plot !== 1'b0) begin n_fail++; $display("FAIL empty_h_done: got done=%b plot=%b want 1/0", done, plot); end
        step();
        n_checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL empty_h_idle: got done=%b ready=%b want 0/1", done, req_ready); end
    endtask

    task automatic test_clip();
        logic       ep;
        logic [7:0] ex;
        logic [6:0] ey;
        // Bottom-right corner: only (158,119) and (159,119) visible
        drive_req(8'd158, 7'd119, 8'd4, 7'd2, 3'b010);
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ep = (k == 0 || k == 1);
            ex = 8'(158 + k % 4);
            ey = 7'(119 + k / 4);
            n_checks++; if (plot !== ep) begin n_fail++; $display("FAIL clip_plot k=%0d: got %b want %b", k, plot, ep); end
            n_checks++; if (plot_x !== ex || plot_y !== ey) begin n_fail++; $display("FAIL clip_xy k=%0d: got (%0d,%0d) want (%0d,%0d)", k, plot_x, plot_y, ex, ey); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL clip_early_done k=%0d: got %b want 0", k, done); end
            step();
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clip_done: got %b want 1", done); end
        step();
        // Column sum passes 255: low bits wrap but nothing may plot
        drive_req(8'd250, 7'd0, 8'd10, 7'd1, 3'b001);
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ex = 8'(250 + k);
            n_checks++; if (plot !== 1'b0 || plot_x !== ex) begin n_fail++; $display("FAIL clip_xwrap k=%0d: got plot=%b x=%0d want 0/%0d", k, plot, plot_x, ex); end
            step();
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clip_xwrap_done: got %b want 1", done); end
        step();
        // Row sum passes 127
        drive_req(8'd0, 7'd125, 8'd1, 7'd5, 3'b001);
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ey = 7'(125 + k);
            n_checks++; if (plot !== 1'b0 || plot_y !== ey) begin n_fail++; $display("FAIL clip_ywrap k=%0d: got plot=%b y=%0d want 0/%0d", k, plot, plot_y, ey); end
            step();
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clip_ywrap_done: got %b want 1", done); end
        step();
    endtask

    task automatic test_full_screen();
        int         plot_errs;
        int         xy_errs;
        int         done_errs;
        logic [7:0] last_x;
        logic [6:0] last_y;
        plot_errs = 0; xy_errs = 0; done_errs = 0;
        last_x = 8'd0; last_y = 7'd0;
        drive_req(8'd0, 7'd0, 8'd160, 7'd120, 3'b110);
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 19200; k++) begin
            if (plot !== 1'b1) plot_errs++;
            if (plot_x !== 8'(k % 160) || plot_y !== 7'(k / 160)) xy_errs++;
            if (done !== 1'b0) done_errs++;
            if (k == 19199) begin last_x = plot_x; last_y = plot_y; end
            step();
        end
        n_checks++; if (plot_errs !== 0) begin n_fail++; $display("FAIL full_plot: got %0d cycles without plot want 0", plot_errs); end
        n_checks++; if (xy_errs !== 0) begin n_fail++; $display("FAIL full_xy: got %0d coordinate errors want 0", xy_errs); end
        n_checks++; if (done_errs !== 0) begin n_fail++; $display("FAIL full_early_done: got %0d cycles want 0", done_errs); end
        n_checks++; if (last_x !== 8'd159 || last_y !== 7'd119) begin n_fail++; $display("FAIL full_last: got (%0d,%0d) want (159,119)", last_x, last_y); end
        n_checks++; if (done !== 1'b1 || plot !== 1'b0) begin n_fail++; $display("FAIL full_done: got done=%b plot=%b want 1/0", done, plot); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ex;
        logic [6:0] ey;
        drive_req(8'd20, 7'd30, 8'd2, 7'd2, 3'b001);
        step();
        // Second request presented immediately and held through the first one
        drive_req(8'd40, 7'd50, 8'd3, 7'd1, 3'b110);
        for (int k = 0; k < 4; k++) begin
            ex = 8'(20 + k % 2);
            ey = 7'(30 + k / 2);
            n_checks++; if (plot !== 1'b1 || plot_x !== ex || plot_y !== ey) begin n_fail++; $display("FAIL b2b_a_px k=%0d: got plot=%b (%0d,%0d) want 1 (%0d,%0d)", k, plot, plot_x, plot_y, ex, ey); end
            n_checks++; if (color !== 3'b001 || req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_a_ctrl k=%0d: got color=%b ready=%b want 001/0", k, color, req_ready); end
            step();
        end
        n_checks++; if (done !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_a_done: got done=%b ready=%b want 1/0", done, req_ready); end
        step();
        n_checks++; if (req_ready !== 1'b1 || plot !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got ready=%b plot=%b done=%b want 1/0/0", req_ready, plot, done); end
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ex = 8'(40 + k);
            n_checks++; if (plot !== 1'b1 || plot_x !== ex || plot_y !== 7'd50) begin n_fail++; $display("FAIL b2b_b_px k=%0d: got plot=%b (%0d,%0d) want 1 (%0d,50)", k, plot, plot_x, plot_y, ex); end
            n_checks++; if (color !== 3'b110) begin n_fail++; $display("FAIL b2b_b_color k=%0d: got %b want 110", k, color); end
            step();
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_b_done: got %b want 1", done); end
        step();
        n_checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got done=%b ready=%b want 0/1", done, req_ready); end
    endtask

    task automatic test_reset_mid_draw();
        drive_req(8'd0, 7'd0, 8'd8, 7'd8, 3'b111);
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (plot !== 1'b1 || plot_x !== 8'(k) || plot_y !== 7'd0) begin n_fail++; $display("FAIL mid_pre k=%0d: got plot=%b (%0d,%0d) want 1 (%0d,0)", k, plot, plot_x, plot_y, k); end
            step();
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++; if (plot !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_async: got plot=%b done=%b want 0/0", plot, done); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", req_ready); end
        n_checks++; if (plot_x !== 8'd0 || plot_y !== 7'd0 || color !== 3'd0) begin n_fail++; $display("FAIL mid_outs: got (%0d,%0d) color=%0d want (0,0) 0", plot_x, plot_y, color); end
        step();
        step();
        resetn = 1'b1;
        step();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b want 1", req_ready); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (done !== 1'b0 || plot !== 1'b0) begin n_fail++; $display("FAIL mid_no_done k=%0d: got done=%b plot=%b want 0/0", k, done, plot); end
            if (k < 3) step();
        end
        drive_req(8'd3, 7'd4, 8'd2, 7'd1, 3'b101);
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (plot !== 1'b1 || plot_x !== 8'(3 + k) || plot_y !== 7'd4 || color !== 3'b101) begin n_fail++; $display("FAIL mid_new_px k=%0d: got plot=%b (%0d,%0d) c=%b want 1 (%0d,4) 101", k, plot, plot_x, plot_y, color, 3 + k); end
            step();
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mid_new_done: got %b want 1", done); end
        step();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_x     = 8'd0;
        req_y     = 7'd0;
        req_w     = 8'd0;
        req_h     = 7'd0;
        req_color = 3'd0;
        test_reset();
        test_basic();
        test_empty();
        test_clip();
        test_full_screen();
        test_back_to_back();
        test_reset_mid_draw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
